vout_deadtime: RTL and testbench

VOUT_DEADTIME -- requirements
Module: vout_deadtime

---
 rtl/vout_deadtime_pkg.sv | 16 +
 rtl/vout_deadtime_sync.sv | 27 ++
 rtl/vout_deadtime.sv | 128 ++++++++++++
 tb/tb_vout_deadtime.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vout_deadtime_pkg.sv
// Shared types and constants for the vout_deadtime half-bridge dead-band generator.
package vout_deadtime_pkg;

  typedef enum logic [2:0] {
    OFF,
    LO,
    DT_H,
    HI,
    DT_L
  } dt_state_e;

  localparam int unsigned DT_CNT_W     = 16;
  localparam int unsigned DEADTIME_MIN = 1;
  localparam int unsigned DEADTIME_MAX = 65535;

endpackage

// File: rtl/vout_deadtime_sync.sv
// Input register stage: a single flop (STAGES=1) or a 2-flop synchroniser (STAGES=2).
module vout_deadtime_sync #(
  parameter int unsigned STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] q;

  if (STAGES == 1) begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= din;
    end
  end else begin : g_chain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= {q[STAGES-2:0], din};
    end
  end

  assign dout = q[STAGES-1];

endmodule

// File: rtl/vout_deadtime.sv
// Dead-band gate-drive generator for one half-bridge leg, driven by a single-ended PWM.
// Define VOUT_DEADTIME_SYNC_EN to pass pwm_in, fault and enable through 2-flop synchronisers.
module vout_deadtime
  import vout_deadtime_pkg::*;
#(
  parameter int unsigned DEADTIME  = 16,
  parameter bit          INVERT_LO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  input  logic enable,
  input  logic fault,
  input  logic fault_clr,
  output logic out_hi,
  output logic out_lo,
  output logic fault_latched
);

`ifdef VOUT_DEADTIME_SYNC_EN
  localparam int unsigned SYNC_STAGES = 2;
`else
  localparam int unsigned SYNC_STAGES = 1;
`endif

  localparam int unsigned DT_EFF = (DEADTIME < DEADTIME_MIN) ? DEADTIME_MIN :
                                   (DEADTIME > DEADTIME_MAX) ? DEADTIME_MAX : DEADTIME;
  localparam logic [DT_CNT_W-1:0] DT_LOAD = DT_CNT_W'(DT_EFF - 1);

  logic pwm_q, en_q, fault_q;

  vout_deadtime_sync #(.STAGES(SYNC_STAGES)) u_sync_pwm (
    .clk(clk), .rst_n(rst_n), .din(pwm_in), .dout(pwm_q));
  vout_deadtime_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk(clk), .rst_n(rst_n), .din(enable), .dout(en_q));
  vout_deadtime_sync #(.STAGES(SYNC_STAGES)) u_sync_fault (
    .clk(clk), .rst_n(rst_n), .din(fault), .dout(fault_q));

  // Raw fault also blocks a coincident clear, so a same-cycle fault is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      fault_latched <= 1'b0;
    else if (fault_q)                fault_latched <= 1'b1;
    else if (fault_clr && !fault)    fault_latched <= 1'b0;
  end

  dt_state_e           state, state_nxt;
  logic [DT_CNT_W-1:0] dt_cnt, cnt_nxt;
  logic                dt_full, full_nxt;
  logic                lo_act;
  logic                off_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OFF;
      dt_cnt  <= '0;
      dt_full <= 1'b0;
      out_hi  <= 1'b0;
      lo_act  <= 1'b0;
    end else begin
      state   <= state_nxt;
      dt_cnt  <= cnt_nxt;
      dt_full <= full_nxt;
      out_hi  <= (state_nxt == HI);
      lo_act  <= (state_nxt == LO);
    end
  end

  // dt_full marks a dead band entered from OFF: it must run to expiry even if
  // pwm_q is already high, since out_lo may have been the last side conducting.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = dt_cnt;
    full_nxt  = dt_full;
    off_req   = !en_q || fault_latched;
    if (state != OFF && off_req) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
      full_nxt  = 1'b0;
    end else begin
      case (state)
        OFF: if (!off_req) begin
          state_nxt = DT_L;
          cnt_nxt   = DT_LOAD;
          full_nxt  = 1'b1;
        end
        LO: if (pwm_q) begin
          state_nxt = DT_H;
          cnt_nxt   = DT_LOAD;
          full_nxt  = 1'b0;
        end
        DT_H: begin
          if (!pwm_q) begin
            state_nxt = LO;
            cnt_nxt   = '0;
          end else if (dt_cnt == '0) begin
            state_nxt = HI;
          end else begin
            cnt_nxt = dt_cnt - DT_CNT_W'(1);
          end
        end
        HI: if (!pwm_q) begin
          state_nxt = DT_L;
          cnt_nxt   = DT_LOAD;
          full_nxt  = 1'b0;
        end
        DT_L: begin
          if (pwm_q && !dt_full) begin
            state_nxt = HI;
            cnt_nxt   = '0;
          end else if (dt_cnt == '0) begin
            state_nxt = pwm_q ? HI : LO;
            full_nxt  = 1'b0;
          end else begin
            cnt_nxt = dt_cnt - DT_CNT_W'(1);
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
          full_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign out_lo = lo_act ^ INVERT_LO;

endmodule

// File: tb/tb_vout_deadtime.sv
// Directed bench for vout_deadtime: DEADTIME=4 main instance plus a DEADTIME=1, INVERT_LO=1 instance.
module tb_vout_deadtime;

`ifdef VOUT_DEADTIME_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n, pwm_in, enable, fault, fault_clr;
  logic out_hi, out_lo, fault_latched;
  logic hi1, lo1, fl1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vout_deadtime #(.DEADTIME(4), .INVERT_LO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable), .fault(fault),
    .fault_clr(fault_clr), .out_hi(out_hi), .out_lo(out_lo), .fault_latched(fault_latched));

  vout_deadtime #(.DEADTIME(1), .INVERT_LO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable), .fault(fault),
    .fault_clr(fault_clr), .out_hi(hi1), .out_lo(lo1), .fault_latched(fl1));

  task automatic check(input string tag, input int obs, input int want);
    n_checks++;
    if (obs != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int duty_tab [16] = '{32, 44, 55, 61, 64, 61, 55, 44, 32, 20, 9, 3, 0, 3, 9, 20};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_on, lo1_on, lo_off, lo1_off, hi_on, hi1_on, lo_back, hi_any, fl_on, hi_off, fl_off, drops;
    int phase, idx, overlap, overlap1;
    int act [2];
    int idle [2];
    int prev [2];
    int min_gap [2];

    rst_n = 1'b0; pwm_in = 1'b0; enable = 1'b1; fault = 1'b0; fault_clr = 1'b0;
    tick(); tick(); tick();
    check("rst_hi", out_hi, 0);
    check("rst_lo", out_lo, 0);
    check("rst_fl", fault_latched, 0);
    check("rst_lo1_inv", lo1, 1);
    check("rst_fl1", fl1, 0);

    // Startup: OFF -> DT_L full band -> LO
    rst_n = 1'b1;
    lo_on = -1; lo1_on = -1; hi_any = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_lo && lo_on < 0) lo_on = c;
      if (!lo1 && lo1_on < 0) lo1_on = c;
      if (out_hi) hi_any++;
    end
    check("start_lo", lo_on, LAT + 4);
    check("start_lo1", lo1_on, LAT + 1);
    check("start_no_hi", hi_any, 0);

    // Test 1: pwm rise held 20 cycles
    pwm_in = 1'b1;
    lo_off = -1; hi_on = -1; lo1_off = -1; hi1_on = -1; overlap = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (!out_lo && lo_off < 0) lo_off = c;
      if (out_hi && hi_on < 0) hi_on = c;
      if (lo1 && lo1_off < 0) lo1_off = c;
      if (hi1 && hi1_on < 0) hi1_on = c;
      if (out_hi && out_lo) overlap++;
    end
    check("t1_lo_fall", lo_off, LAT);
    check("t1_dead", hi_on - lo_off, 4);
    check("t1_hi_end", out_hi, 1);
    check("t1_overlap", overlap, 0);
    check("t1_lo1_fall", lo1_off, LAT);
    check("t1_dead1", hi1_on - lo1_off, 1);

    // Test 2: 2-cycle pwm pulse is swallowed by the dead band
    pwm_in = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    check("t2_pre_lo", out_lo, 1);
    pwm_in = 1'b1;
    lo_off = -1; lo_back = -1; hi_any = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 2) pwm_in = 1'b0;
      if (!out_lo && lo_off < 0) lo_off = c;
      if (out_lo && lo_off > 0 && lo_back < 0) lo_back = c;
      if (out_hi) hi_any++;
    end
    check("t2_lo_fall", lo_off, LAT);
    check("t2_lo_back", lo_back - lo_off, 2);
    check("t2_no_hi", hi_any, 0);

    // Test 3: fault in HI, then clear
    pwm_in = 1'b1;
    for (int c = 0; c < 30 && !out_hi; c++) tick();
    check("t3_reach_hi", out_hi, 1);
    tick(); tick();
    fault = 1'b1;
    fl_on = -1; hi_off = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) fault = 1'b0;
      if (fault_latched && fl_on < 0) fl_on = c;
      if (!out_hi && hi_off < 0) hi_off = c;
    end
    check("t3_fl_set", fl_on, LAT);
    check("t3_hi_off", hi_off, LAT + 1);
    check("t3_fl1_set", fl1, 1);
    pwm_in = 1'b0;
    tick(); tick(); tick();
    check("t3_lo_while_fault", out_lo, 0);
    fault_clr = 1'b1;
    fl_off = -1; lo_on = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) fault_clr = 1'b0;
      if (!fault_latched && fl_off < 0) fl_off = c;
      if (out_lo && lo_on < 0) lo_on = c;
    end
    check("t3_fl_clr", fl_off, 1);
    check("t3_lo_after_clr", lo_on, 6);
    check("t3_fl1_clr", fl1, 0);

    // Test 4: simultaneous fault and clear keeps the latch
    fault = 1'b1;
    tick();
    fault = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("t4_fl_pre", fault_latched, 1);
    fault = 1'b1; fault_clr = 1'b1;
    tick();
    fault = 1'b0; fault_clr = 1'b0;
    drops = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (!fault_latched) drops++;
    end
    check("t4_simul_hold", drops, 0);
    fault = 1'b1;
    tick(); tick(); tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tick(); tick();
    check("t4_clr_while_fault", fault_latched, 1);
    fault = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("t4_clr_ok", fault_latched, 0);

    // Test 5: sine-PWM pattern with random enable toggles
    phase = 0; idx = 0; overlap = 0; overlap1 = 0;
    for (int k = 0; k < 2; k++) begin
      idle[k] = 0; prev[k] = 0; min_gap[k] = 1_000_000;
    end
    for (int c = 0; c < 20000; c++) begin
      pwm_in = (phase < duty_tab[idx]);
      phase++;
      if (phase == 64) begin
        phase = 0;
        idx = (idx + 1) % 16;
      end
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      tick();
      if (out_hi && out_lo) overlap++;
      if (hi1 && !lo1) overlap1++;
      act[0] = out_hi ? 1 : (out_lo ? 2 : 0);
      act[1] = hi1 ? 1 : (!lo1 ? 2 : 0);
      for (int k = 0; k < 2; k++) begin
        if (act[k] == 0) idle[k]++;
        else begin
          if (prev[k] != 0 && prev[k] != act[k] && idle[k] < min_gap[k]) min_gap[k] = idle[k];
          prev[k] = act[k];
          idle[k] = 0;
        end
      end
    end
    check("t5_overlap", overlap, 0);
    check("t5_overlap1", overlap1, 0);
    check("t5_min_gap", min_gap[0], 4);
    check("t5_min_gap1", min_gap[1], 1);

    // Test 6: reset mid DT_H, then first conduction via full dead band
    enable = 1'b1; pwm_in = 1'b0;
    for (int c = 0; c < 40 && !out_lo; c++) tick();
    check("t6_reach_lo", out_lo, 1);
    pwm_in = 1'b1;
    for (int c = 0; c < LAT + 1; c++) tick();
    check("t6_in_dth_lo", out_lo, 0);
    check("t6_in_dth_hi", out_hi, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_hi", out_hi, 0);
    check("t6_rst_lo", out_lo, 0);
    check("t6_rst_lo1", lo1, 1);
    tick();
    check("t6_rst_hold_hi", out_hi, 0);
    rst_n = 1'b1;
    hi_on = -1; lo_on = -1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (out_hi && hi_on < 0) hi_on = c;
      if (out_lo && lo_on < 0) lo_on = c;
    end
    check("t6_hi_latency", hi_on, LAT + 4);
    check("t6_no_lo", lo_on, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
